// File: rtl/alu_pkg.sv
// Shared opcode/state types and helpers for the multi-cycle ALU.
package alu_pkg;

  // 4-bit operation codes; the original 3-bit ALU encodings are kept in the low bits.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // True for operations that go through the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// The first iteration is performed on the start edge directly from a/b, so
// WIDTH iterations finish one cycle before done is seen by the controller.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);
  import alu_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             mul_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] src_hi, src_lo, src_b;
  logic             src_mul;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] hi_d, lo_d;

  // One iteration step; operands come straight from the inputs on the start edge.
  always_comb begin
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? a  : lo_q;
    src_b   = start ? b  : b_q;
    src_mul = start ? (op == OP_MUL) : mul_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // multiply: conditionally add multiplicand, then shift acc:multiplier right
    add_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);

    // divide: shift next dividend bit into remainder, subtract if it fits
    shifted = {src_hi, src_lo[WIDTH-1]};
    trial   = shifted - {1'b0, src_b};
    fits    = (shifted >= {1'b0, src_b});

    if (src_mul) begin
      hi_d = add_sum[WIDTH:1];
      lo_d = {add_sum[0], src_lo[WIDTH-1:1]};
    end else begin
      hi_d = fits ? WIDTH'(trial) : WIDTH'(shifted);
      lo_d = {src_lo[WIDTH-2:0], fits};
    end
  end

  // Working registers, remaining-iteration counter and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        b_q   <= b;
        mul_q <= (op == OP_MUL);
        cnt_q <= CNT_W'(WIDTH - 1);
      end else if (cnt_q != '0) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        cnt_q  <= cnt_q - CNT_W'(1);
        done_q <= (cnt_q == CNT_W'(1));
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on input and output.
// Single-cycle ops complete in one cycle; MUL/DIVU take WIDTH BUSY cycles.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);
  import alu_pkg::*;

  alu_state_e       state_q, state_d;
  logic             accept;
  logic             is_mc;
  logic             mc_start;
  logic             ld_single;
  logic             ld_mc;
  logic             div_bz_q;

  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;

  logic [WIDTH-1:0] mc_hi, mc_lo;
  logic             mc_done;

  // Single-cycle operations and illegal-opcode detection.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (alucontrol)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: sc_res = WIDTH'(a < b);
      OP_MUL:  sc_res = '0;
      OP_DIVU: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // Next-state, handshake and load enables.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    is_mc     = is_multicycle(alucontrol);
    mc_start  = 1'b0;
    ld_single = 1'b0;
    ld_mc     = 1'b0;

    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE: if (accept) state_d = is_mc ? BUSY : DONE;
      BUSY: if (mc_done) state_d = DONE;
      DONE: begin
        if (out_ready) state_d = accept ? (is_mc ? BUSY : DONE) : IDLE;
      end
      default: state_d = IDLE;
    endcase

    mc_start  = accept && is_mc;
    ld_single = accept && !is_mc;
    ld_mc     = (state_q == BUSY) && mc_done;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Result/flag registers; they only change when a new result is produced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      div_bz_q    <= 1'b0;
    end else begin
      out_valid <= (state_d == DONE);
      if (mc_start) div_bz_q <= (alucontrol == OP_DIVU) && (b == '0);
      if (ld_single) begin
        result      <= sc_res;
        result_hi   <= '0;
        zero        <= (sc_res == '0);
        div_by_zero <= 1'b0;
        illegal_op  <= sc_ill;
      end else if (ld_mc) begin
        result      <= mc_lo;
        result_hi   <= mc_hi;
        zero        <= (mc_lo == '0);
        div_by_zero <= div_bz_q;
        illegal_op  <= 1'b0;
      end
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mc_start),
    .op      (alucontrol),
    .a       (a),
    .b       (b),
    .hi      (mc_hi),
    .lo      (mc_lo),
    .done    (mc_done)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors plus a transaction-level model.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result, result_hi;
  logic [3:0]   alucontrol;
  logic         zero, div_by_zero, illegal_op;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         dbz;
    logic         ill;
    int           rc;
  } exp_t;

  exp_t q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alucontrol  (alucontrol),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    logic [2*W-1:0] p;
    m.res = '0; m.hi = '0; m.dbz = 1'b0; m.ill = 1'b0; m.rc = 0;
    case (op)
      4'b0000: m.res = x & y;
      4'b0001: m.res = x | y;
      4'b0010: m.res = x + y;
      4'b0110: m.res = x - y;
      4'b0111: m.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b0101: m.res = (x < y) ? 1 : 0;
      4'b1000: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m.res = p[W-1:0];
        m.hi  = p[2*W-1:W];
      end
      4'b1001: begin
        if (y == 0) begin m.res = '1; m.hi = x; m.dbz = 1'b1; end
        else begin m.res = x / y; m.hi = x % y; end
      end
      default: m.ill = 1'b1;
    endcase
    m.z = (m.res == 0);
    return m;
  endfunction

  // Per-cycle compare of the DUT against the transaction model.
  always @(negedge clk) begin : mon
    logic ov_exp;
    logic ir_exp;
    exp_t e;
    cyc++;
    if (!reset_n) begin
      q.delete();
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_in_ready", in_ready, 1'b1);
      checkw("rst_result", result, '0);
      checkw("rst_result_hi", result_hi, '0);
      check1("rst_flags", zero | div_by_zero | illegal_op, 1'b0);
    end else begin
      ov_exp = (q.size() != 0) && (cyc >= q[0].rc);
      ir_exp = (q.size() == 0) || (ov_exp && out_ready);
      check1("mon_out_valid", out_valid, ov_exp);
      check1("mon_in_ready", in_ready, ir_exp);
      if (ov_exp) begin
        checkw("mon_result", result, q[0].res);
        checkw("mon_result_hi", result_hi, q[0].hi);
        check1("mon_zero", zero, q[0].z);
        check1("mon_div_by_zero", div_by_zero, q[0].dbz);
        check1("mon_illegal_op", illegal_op, q[0].ill);
      end
      if (ov_exp && out_ready) void'(q.pop_front());
      if (in_valid && ir_exp) begin
        e = model(alucontrol, a, b);
        e.rc = cyc + (((alucontrol == 4'b1000) || (alucontrol == 4'b1001)) ? int'(W) + 1 : 1);
        q.push_back(e);
      end
    end
  end

  // Present one operation and hold it until accepted (bounded).
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic rdy;
    int   tries;
    tries = 0;
    alucontrol = op; a = av; b = bv; in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!rdy && tries < 200);
    check1("send_accept", rdy, 1'b1);
    in_valid = 1'b0;
  endtask

  // Expect the result exactly lat cycles after acceptance, with literal values.
  task automatic expect_out(input string name, input int lat, input logic [W-1:0] er,
                            input logic [W-1:0] eh, input logic ez, input logic ed, input logic ei);
    int early;
    int rdy_cnt;
    early = 0;
    rdy_cnt = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) begin
        if (out_valid) early++;
        if (in_ready) rdy_cnt++;
      end
    end
    checkw({name, "_early_valid"}, W'(early), '0);
    checkw({name, "_busy_in_ready"}, W'(rdy_cnt), '0);
    check1({name, "_out_valid"}, out_valid, 1'b1);
    checkw({name, "_result"}, result, er);
    checkw({name, "_result_hi"}, result_hi, eh);
    check1({name, "_zero"}, zero, ez);
    check1({name, "_div_by_zero"}, div_by_zero, ed);
    check1({name, "_illegal_op"}, illegal_op, ei);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t e;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alucontrol = 4'b0000;

    // pin the model against hand-computed values
    e = model(4'b1000, 32'hFFFFFFFF, 32'h00000002);
    checkw("pin_mul_lo", e.res, 32'hFFFFFFFE);
    checkw("pin_mul_hi", e.hi, 32'h00000001);
    e = model(4'b1001, 32'h00000064, 32'h00000007);
    checkw("pin_div_q", e.res, 32'h0000000E);
    checkw("pin_div_r", e.hi, 32'h00000002);
    e = model(4'b1001, 32'h00000064, 32'h00000000);
    checkw("pin_div0_q", e.res, 32'hFFFFFFFF);
    check1("pin_div0_flag", e.dbz, 1'b1);
    e = model(4'b0111, 32'hFFFFFFFF, 32'h00000001);
    checkw("pin_slt", e.res, 32'h00000001);

    repeat (3) @(posedge clk);
    #1;
    check1("reset_in_ready", in_ready, 1'b1);
    check1("reset_out_valid", out_valid, 1'b0);
    checkw("reset_result", result, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: SUB equal and off-by-one
    send(4'b0110, 32'h0000000B, 32'h0000000B);
    expect_out("sub_eq", 1, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0);
    send(4'b0110, 32'h0000000B, 32'h0000000A);
    expect_out("sub_one", 1, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0);

    // 2: back-to-back SLT then SLTU
    send(4'b0111, 32'hFFFFFFFF, 32'h00000001);
    alucontrol = 4'b0101; a = 32'hFFFFFFFF; b = 32'h00000001; in_valid = 1'b1;
    @(negedge clk);
    check1("b2b_slt_valid", out_valid, 1'b1);
    checkw("b2b_slt_result", result, 32'h00000001);
    check1("b2b_slt_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check1("b2b_sltu_valid", out_valid, 1'b1);
    checkw("b2b_sltu_result", result, 32'h00000000);
    check1("b2b_sltu_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 3: MUL
    send(4'b1000, 32'hFFFFFFFF, 32'h00000002);
    expect_out("mul", 33, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);

    // 4: DIVU, including divide by zero
    send(4'b1001, 32'h00000064, 32'h00000007);
    expect_out("divu", 33, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0);
    send(4'b1001, 32'h00000064, 32'h00000000);
    expect_out("divu0", 33, 32'hFFFFFFFF, 32'h00000064, 1'b0, 1'b1, 1'b0);

    // 5: backpressure then illegal opcode
    out_ready = 1'b0;
    send(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("bp_valid", out_valid, 1'b1);
      checkw("bp_result", result, 32'h80000000);
      check1("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check1("bp_single_transfer", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(4'b1111, 32'h00001234, 32'h00005678);
    expect_out("illegal", 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // 6: reset in the middle of a MUL
    send(4'b0010, 32'h00000011, 32'h00000022);
    expect_out("add_pre", 1, 32'h00000033, 32'h0, 1'b0, 1'b0, 1'b0);
    send(4'b1000, 32'h00000003, 32'h00000005);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkw("async_rst_result", result, 32'h0);
    check1("async_rst_out_valid", out_valid, 1'b0);
    check1("async_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'b0010, 32'h00000002, 32'h00000003);
    expect_out("add_post_rst", 1, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
